io_uart_tx: RTL and testbench

- UART transmitter that drives one fabric bidirectional pad pair (io_out bit plus io_oeb bit) from the user top level.
- Outbound counterpart to the pad-input path: user logic pushes bytes, the block buffers them and serialises them onto the pad.
- Intended for pad bring-up, oscillator frequency readout and debug streaming.
- Frame format: 8 data bits, LSB first, optional parity, 1 or 2 stop bits.

---
 rtl/io_uart_tx.sv | 238 +++++++++++++++++++++++
 tb/tb_io_uart_tx.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : io_uart_tx
//  Purpose  : UART transmitter driving one bidirectional fabric pad pair.
//             User logic pushes bytes into a small FIFO. The FSM serialises
//             them as 8N1/8E1/8O1 (or 2 stop bits) frames, LSB first.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   system clock
//    rst_n    in   asynchronous active-low reset (synchronous release)
//    en       in   transmitter enable; 0 floats the pad
//    data_i   in   [7:0] byte to send
//    valid_i  in   data_i valid; accepted when valid_i && ready_o
//    ready_o  out  FIFO can accept a byte (registered)
//    io_out   out  serial line to pad I input (registered, idles high)
//    io_oeb   out  pad tristate control, 0 = driving, 1 = hi-Z (registered)
//    busy_o   out  frame in progress or FIFO non-empty
//    level_o  out  [clog2(FIFO_DEPTH):0] FIFO occupancy
// ============================================================================
module io_uart_tx #(
    parameter int CLKS_PER_BIT = 16,   // 2..65535
    parameter int FIFO_DEPTH   = 4,    // power of two, 2..16
    parameter int PARITY       = 0,    // 0 none, 1 even, 2 odd
    parameter int STOP_BITS    = 1     // 1 or 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          io_out,
    output logic                          io_oeb,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam int              LW         = AW + 1;
    localparam logic [15:0]     BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0]   DEPTH_L    = LW'(FIFO_DEPTH);
    localparam logic [2:0]      STOP_LAST  = 3'(STOP_BITS - 1);
    localparam bit              HAS_PARITY = (PARITY != 0);
    localparam bit              ODD_PARITY = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          ready_q;

    // ------------------------------------------------------------------
    // Transmit FSM registers
    // ------------------------------------------------------------------
    state_t        state_q;
    logic [15:0]   baud_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic          io_out_q;
    logic          io_oeb_q;

    logic          do_push;
    logic          do_pop;
    logic          baud_end;
    logic          stop_done;
    logic [7:0]    pop_data;

    assign baud_end  = (baud_q == BAUD_LAST);
    assign stop_done = (state_q == S_STOP) && baud_end && (bit_cnt_q == STOP_LAST);

    // ready_q already reflects the level after the previous edge, so a push
    // can never land in a full FIFO.
    assign do_push   = valid_i && ready_q;

    // Pop only on registered level: a byte pushed this cycle into an empty
    // FIFO is not visible until the next cycle. Pops happen from IDLE or at
    // the very last cycle of STOP so consecutive frames abut.
    assign do_pop    = en && (level_q != '0) &&
                       ((state_q == S_IDLE) || stop_done);

    assign pop_data  = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            ready_q <= (level_d < DEPTH_L);
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM with registered pad outputs.
    // io_out_q is derived from the state held before the edge, so the line
    // trails the state by exactly one cycle for every bit. That keeps all
    // bit widths equal and gives the two-cycle push-to-start-bit latency.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            io_out_q  <= 1'b1;
            io_oeb_q  <= 1'b1;
        end else begin
            io_oeb_q <= ~en;

            case (state_q)
                S_START:  io_out_q <= 1'b0;
                S_DATA:   io_out_q <= shift_q[0];
                S_PARITY: io_out_q <= parity_q;
                default:  io_out_q <= 1'b1;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (do_pop) begin
                        shift_q   <= pop_data;
                        parity_q  <= (^pop_data) ^ ODD_PARITY;
                        baud_q    <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_START;
                    end
                end

                S_START: begin
                    if (baud_end) begin
                        baud_q    <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end

                S_DATA: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_q <= '0;
                            state_q   <= HAS_PARITY ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end

                S_PARITY: begin
                    if (baud_end) begin
                        baud_q    <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_STOP;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end

                S_STOP: begin
                    // bit_cnt_q counts stop bits here
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_cnt_q == STOP_LAST) begin
                            bit_cnt_q <= '0;
                            if (do_pop) begin
                                shift_q  <= pop_data;
                                parity_q <= (^pop_data) ^ ODD_PARITY;
                                state_q  <= S_START;
                            end else begin
                                state_q  <= S_IDLE;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign io_out  = io_out_q;
    assign io_oeb  = io_oeb_q;
    assign ready_o = ready_q;
    assign level_o = level_q;
    assign busy_o  = (state_q != S_IDLE) || (level_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_io_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_io_uart_tx
//  Purpose  : Self-checking bench for io_uart_tx. Three instances share the
//             inputs: idx0 = no parity / 1 stop, idx1 = even / 1 stop,
//             idx2 = odd / 2 stops. Expected line levels come from a frame
//             model built from bit positions.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_uart_tx;

    localparam int C     = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] data;
    logic       valid;

    logic [2:0] rdy;
    logic [2:0] txo;
    logic [2:0] oeb;
    logic [2:0] busy;
    logic [2:0] lvl [3];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    io_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .PARITY(0), .STOP_BITS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .data_i(data), .valid_i(valid),
        .ready_o(rdy[0]), .io_out(txo[0]), .io_oeb(oeb[0]), .busy_o(busy[0]), .level_o(lvl[0]));

    io_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .PARITY(1), .STOP_BITS(1)) u_even (
        .clk(clk), .rst_n(rst_n), .en(en), .data_i(data), .valid_i(valid),
        .ready_o(rdy[1]), .io_out(txo[1]), .io_oeb(oeb[1]), .busy_o(busy[1]), .level_o(lvl[1]));

    io_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .PARITY(2), .STOP_BITS(2)) u_odd (
        .clk(clk), .rst_n(rst_n), .en(en), .data_i(data), .valid_i(valid),
        .ready_o(rdy[2]), .io_out(txo[2]), .io_oeb(oeb[2]), .busy_o(busy[2]), .level_o(lvl[2]));

    // ---------------- reference model ----------------
    function automatic int par_of(input logic [1:0] idx);
        return (idx == 2'd1) ? 1 : (idx == 2'd2) ? 2 : 0;
    endfunction

    function automatic int stp_of(input logic [1:0] idx);
        return (idx == 2'd2) ? 2 : 1;
    endfunction

    function automatic int nbits(input int par, input int stops);
        return 1 + 8 + ((par != 0) ? 1 : 0) + stops;
    endfunction

    // Line level of bit position k within a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int par, input int stops, input int k);
        logic [7:0] t;
        if (k == 0) return 1'b0;
        if (k <= 8) begin
            t = b >> (k - 1);
            return t[0];
        end
        if ((par != 0) && (k == 9)) return (par == 1) ? (^b) : ~(^b);
        return 1'b1;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [1:0] idx, input logic [7:0] b, output int acc);
        int n;
        n = 0;
        while (rdy[idx] !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        n_cmp++;
        if (rdy[idx] !== 1'b1) begin
            n_bad++;
            $display("FAIL push_ready idx=%0d: got ready %b, required 1 within 1000 cycles", idx, rdy[idx]);
        end
        data  = b;
        valid = 1'b1;
        tick();
        acc   = cyc;
        valid = 1'b0;
        data  = 8'($urandom);
    endtask

    task automatic wait_start(input logic [1:0] idx, input int max, output int s, output bit ok);
        int n;
        n = 0;
        while (txo[idx] !== 1'b0 && n < max) begin
            tick();
            n++;
        end
        ok = (txo[idx] === 1'b0);
        s  = cyc;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL start_seen idx=%0d: got line %b, required 0 within %0d cycles", idx, txo[idx], max);
        end
    endtask

    // Called on the first cycle of the start bit. Every cycle of every bit
    // is checked, which also pins the frame length. When drop_at >= 0, en
    // is dropped at that cycle offset and the pad must float one cycle later.
    task automatic capture(input logic [1:0] idx, input logic [7:0] b, input int drop_at);
        int   par;
        int   stp;
        int   nb;
        logic e;
        logic bad;
        logic seen;
        par = par_of(idx);
        stp = stp_of(idx);
        nb  = nbits(par, stp);
        n_cmp++;
        if (oeb[idx] !== 1'b0) begin
            n_bad++;
            $display("FAIL oeb_drive idx=%0d: got %b, required 0", idx, oeb[idx]);
        end
        for (int k = 0; k < nb; k++) begin
            e    = exp_bit(b, par, stp, k);
            bad  = 1'b0;
            seen = e;
            for (int c = 0; c < C; c++) begin
                if (k != 0 || c != 0) tick();
                if (txo[idx] !== e) begin
                    bad  = 1'b1;
                    seen = txo[idx];
                end
                if ((drop_at >= 0) && (k * C + c == drop_at + 1)) begin
                    n_cmp++;
                    if (oeb[idx] !== 1'b1) begin
                        n_bad++;
                        $display("FAIL oeb_float idx=%0d: got %b, required 1", idx, oeb[idx]);
                    end
                end
                if (k * C + c == drop_at) en = 1'b0;
            end
            n_cmp++;
            if (bad) begin
                n_bad++;
                $display("FAIL frame_bit idx=%0d byte=%02h bit=%0d: got %b, required %b for all %0d cycles",
                         idx, b, k, seen, e, C);
            end
        end
    endtask

    task automatic check_idle(input logic [1:0] idx);
        tick();
        n_cmp++;
        if (txo[idx] !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_high idx=%0d: got %b, required 1", idx, txo[idx]);
        end
        n_cmp++;
        if (busy[idx] !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_clear idx=%0d: got %b, required 0", idx, busy[idx]);
        end
    endtask

    task automatic check_lvl(input logic [1:0] idx, input int want, input string nm);
        n_cmp++;
        if (lvl[idx] !== 3'(want)) begin
            n_bad++;
            $display("FAIL %s idx=%0d: got level %0d, required %0d", nm, idx, lvl[idx], want);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        en    = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp += 5;
        if (txo[0]  !== 1'b1) begin n_bad++; $display("FAIL rst_out: got %b, required 1", txo[0]);   end
        if (oeb[0]  !== 1'b1) begin n_bad++; $display("FAIL rst_oeb: got %b, required 1", oeb[0]);   end
        if (rdy[0]  !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b, required 0", rdy[0]); end
        if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy[0]); end
        if (lvl[0]  !== 3'd0) begin n_bad++; $display("FAIL rst_level: got %0d, required 0", lvl[0]); end
        rst_n = 1'b1;
        tick();
        n_cmp += 3;
        if (oeb[0] !== 1'b0) begin n_bad++; $display("FAIL rel_oeb: got %b, required 0", oeb[0]);     end
        if (txo[0] !== 1'b1) begin n_bad++; $display("FAIL rel_out: got %b, required 1", txo[0]);     end
        if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL rel_ready: got %b, required 1", rdy[0]);   end
        check_lvl(2'd0, 0, "rel_level");
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        int acc;
        int s;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? 8'hA5 : 8'($urandom);
            push(2'd0, b, acc);
            wait_start(2'd0, 20, s, ok);
            if (ok) begin
                n_cmp++;
                if (s - acc != 2) begin
                    n_bad++;
                    $display("FAIL start_latency: got %0d cycles, required 2", s - acc);
                end
                capture(2'd0, b, -1);
                check_idle(2'd0);
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] b;
        int acc;
        int s;
        bit ok;
        for (int idx = 1; idx <= 2; idx++) begin
            do_reset();
            for (int j = 0; j < 2; j++) begin
                b = (j == 0) ? 8'h07 : 8'($urandom);
                push(2'(idx), b, acc);
                wait_start(2'(idx), 20, s, ok);
                if (ok) begin
                    capture(2'(idx), b, -1);
                    check_idle(2'(idx));
                    check_lvl(2'(idx), 0, "par_level");
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        int acc;
        int s;
        bit ok;
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = 8'(8'h11 + i);
            push(2'd0, b, acc);
        end
        check_lvl(2'd0, 4, "fill_level");
        n_cmp++;
        if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b, required 0", rdy[0]); end
        data  = 8'h15;
        valid = 1'b1;
        tick();
        tick();
        tick();
        valid = 1'b0;
        check_lvl(2'd0, 4, "full_push_ignored");
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = 8'(8'h11 + i);
            if (i == 0) begin
                wait_start(2'd0, 20, s, ok);
                if (!ok) return;
            end else begin
                tick();
                n_cmp++;
                if (txo[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_no_gap frame=%0d: got %b, required 0", i, txo[0]);
                end
            end
            check_lvl(2'd0, 3 - i, "b2b_level");
            capture(2'd0, b, -1);
        end
        check_idle(2'd0);
    endtask

    task automatic test_enable();
        logic [7:0] b [3];
        int   acc;
        int   s;
        bit   ok;
        logic moved;
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b[i] = 8'($urandom);
            push(2'd0, b[i], acc);
        end
        en = 1'b1;
        wait_start(2'd0, 20, s, ok);
        if (!ok) return;
        check_lvl(2'd0, 2, "en_level_start");
        capture(2'd0, b[0], 3 * C + 5);
        moved = 1'b0;
        for (int n = 0; n < 4 * C; n++) begin
            tick();
            if (txo[0] !== 1'b1) moved = 1'b1;
        end
        n_cmp++;
        if (moved) begin n_bad++; $display("FAIL en_no_new_frame: got line activity, required steady 1"); end
        check_lvl(2'd0, 2, "en_level_held");
        n_cmp += 2;
        if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL en_busy: got %b, required 1", busy[0]); end
        if (oeb[0]  !== 1'b1) begin n_bad++; $display("FAIL en_oeb_off: got %b, required 1", oeb[0]); end
        en = 1'b1;
        wait_start(2'd0, 20, s, ok);
        if (!ok) return;
        capture(2'd0, b[1], -1);
        tick();
        n_cmp++;
        if (txo[0] !== 1'b0) begin n_bad++; $display("FAIL en_resume_gap: got %b, required 0", txo[0]); end
        capture(2'd0, b[2], -1);
        check_idle(2'd0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int acc;
        int s;
        bit ok;
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 3; i++) push(2'd0, 8'($urandom), acc);
        en = 1'b1;
        wait_start(2'd0, 20, s, ok);
        for (int n = 0; n < 50; n++) tick();
        rst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (txo[0]  !== 1'b1) begin n_bad++; $display("FAIL mid_rst_out: got %b, required 1", txo[0]);   end
        if (oeb[0]  !== 1'b1) begin n_bad++; $display("FAIL mid_rst_oeb: got %b, required 1", oeb[0]);   end
        if (rdy[0]  !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b, required 0", rdy[0]); end
        if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b, required 0", busy[0]); end
        check_lvl(2'd0, 0, "mid_rst_level");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        b = 8'($urandom);
        push(2'd0, b, acc);
        wait_start(2'd0, 20, s, ok);
        if (ok) begin
            n_cmp++;
            if (s - acc != 2) begin
                n_bad++;
                $display("FAIL post_rst_latency: got %0d cycles, required 2", s - acc);
            end
            capture(2'd0, b, -1);
            check_idle(2'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion, required finish before 80000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
